desc_bank_loader: RTL and testbench

- Parametrised successor to the single-register descriptor load path of the NCC engine.
- Accepts a descriptor pixel stream from the host/PCI side over a valid/ready handshake and writes it into a shadow bank.
- Computes the descriptor's pixel sum and sum-of-squares on the fly, for the NCC mean/variance terms.
- Promotes the completed descriptor to the active bank without disturbing a correlation pass in progress.

---
 rtl/ncc_pkg.sv | 23 ++
 rtl/desc_bank_loader_if.sv | 21 ++
 rtl/desc_bank.sv | 39 +++
 rtl/desc_bank_loader.sv | 171 +++++++++++++++++
 tb/tb_desc_bank_loader.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ncc_pkg.sv
// Shared types and width helpers for the NCC descriptor loader.
// Imported by the loader top and its bank sub-module.
package ncc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam int DEF_PIX_W = 8;

  typedef logic [DEF_PIX_W-1:0] pix_t;

  function automatic int sum_w(input int pix_w, input int num_pix);
    return pix_w + $clog2(num_pix + 1);
  endfunction

  function automatic int sq_w(input int pix_w, input int num_pix);
    return 2 * pix_w + $clog2(num_pix + 1);
  endfunction

endpackage

// File: rtl/desc_bank_loader_if.sv
// Pixel stream handshake between the host side and the loader.
// Master drives pixels; slave answers with ready.
interface desc_bank_loader_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_in,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/desc_bank.sv
// Descriptor register bank: indexed pixel write plus bulk copy-in.
// Bulk copy takes priority over the indexed write.
module desc_bank import ncc_pkg::*; #(
  parameter int PIX_W   = 8,
  parameter int NUM_PIX = 256,
  localparam int AW     = $clog2(NUM_PIX),
  localparam int VW     = NUM_PIX * PIX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [PIX_W-1:0] din,
  input  logic          load,
  input  logic [VW-1:0] load_data,
  output logic [VW-1:0] dout
);

  logic [VW-1:0] mem_q, mem_d;

  // next contents: bulk copy, else single pixel write
  always_comb begin
    mem_d = mem_q;
    if (load) begin
      mem_d = load_data;
    end else if (we) begin
      mem_d[addr*PIX_W +: PIX_W] = din;
    end
  end

  // bank storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign dout = mem_q;

endmodule

// File: rtl/desc_bank_loader.sv
// Streams a descriptor into a shadow bank with running sum/sumsq,
// then promotes it to the active bank when the consumer is idle.
module desc_bank_loader import ncc_pkg::*; #(
  parameter int  PIX_W   = 8,
  parameter int  NUM_PIX = 256,
  localparam int SUM_W   = sum_w(PIX_W, NUM_PIX),
  localparam int SQ_W    = sq_w(PIX_W, NUM_PIX),
  localparam int CNT_W   = $clog2(NUM_PIX),
  localparam int VW      = NUM_PIX * PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  desc_bank_loader_if.slave pix,
  input  logic             consumer_busy,
  output logic             load_busy,
  output logic             desc_valid,
  output logic             desc_update,
  output logic [VW-1:0]    desc_out,
  output logic [SUM_W-1:0] desc_sum,
  output logic [SQ_W-1:0]  desc_sumsq
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SQ_W-1:0]  sumsq_q, sumsq_d;
  logic [SUM_W-1:0] act_sum_q, act_sum_d;
  logic [SQ_W-1:0]  act_sumsq_q, act_sumsq_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;

  logic             xfer;
  logic             last;
  logic             promote;
  logic [2*PIX_W-1:0] sq;
  logic [VW-1:0]    shadow_vec;
  logic [VW-1:0]    promote_vec;

  assign xfer = (state_q == LOAD) && pix.pix_valid;
  assign last = (count_q == CNT_W'(NUM_PIX - 1));
  assign sq   = {{PIX_W{1'b0}}, pix.pix_in}
              * {{PIX_W{1'b0}}, pix.pix_in};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state and promote decision
  always_comb begin
    state_d = state_q;
    promote = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer && last) begin
          if (consumer_busy) begin
            state_d = PENDING;
          end else begin
            state_d = IDLE;
            promote = 1'b1;
          end
        end
      end
      PENDING: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!consumer_busy) begin
          state_d = IDLE;
          promote = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    pix.pix_ready = (state_q == LOAD);
    load_busy     = (state_q != IDLE);
  end

  // shadow accumulators and active-side bookkeeping
  always_comb begin
    count_d     = count_q;
    sum_d       = sum_q;
    sumsq_d     = sumsq_q;
    if (state_q == IDLE && start) begin
      count_d = '0;
      sum_d   = '0;
      sumsq_d = '0;
    end else if (xfer) begin
      count_d = count_q + CNT_W'(1);
      sum_d   = sum_q + SUM_W'(pix.pix_in);
      sumsq_d = sumsq_q + SQ_W'(sq);
    end
    act_sum_d   = promote ? sum_d : act_sum_q;
    act_sumsq_d = promote ? sumsq_d : act_sumsq_q;
    valid_d     = valid_q | promote;
    upd_d       = promote;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      act_sum_q   <= '0;
      act_sumsq_q <= '0;
      valid_q     <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      sum_q       <= sum_d;
      sumsq_q     <= sumsq_d;
      act_sum_q   <= act_sum_d;
      act_sumsq_q <= act_sumsq_d;
      valid_q     <= valid_d;
      upd_q       <= upd_d;
    end
  end

  // shadow contents with this cycle's pixel merged in, for direct promote
  always_comb begin
    promote_vec = shadow_vec;
    if (xfer) promote_vec[count_q*PIX_W +: PIX_W] = pix.pix_in;
  end

  desc_bank #(
    .PIX_W   (PIX_W),
    .NUM_PIX (NUM_PIX)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (xfer),
    .addr      (count_q),
    .din       (pix.pix_in),
    .load      (1'b0),
    .load_data ('0),
    .dout      (shadow_vec)
  );

  desc_bank #(
    .PIX_W   (PIX_W),
    .NUM_PIX (NUM_PIX)
  ) u_active (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (1'b0),
    .addr      ('0),
    .din       ('0),
    .load      (promote),
    .load_data (promote_vec),
    .dout      (desc_out)
  );

  assign desc_sum    = act_sum_q;
  assign desc_sumsq  = act_sumsq_q;
  assign desc_valid  = valid_q;
  assign desc_update = upd_q;

endmodule

// File: tb/tb_desc_bank_loader.sv
// Directed bench for desc_bank_loader with NUM_PIX=4, PIX_W=8.
// Each task drives one scenario and checks against hand values.
module tb_desc_bank_loader;

  localparam int PW = 8;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        consumer_busy = 1'b0;
  logic        load_busy;
  logic        desc_valid;
  logic        desc_update;
  logic [31:0] desc_out;
  logic [10:0] desc_sum;
  logic [18:0] desc_sumsq;

  int pass_cnt = 0;
  int total_cnt = 0;

  desc_bank_loader_if #(.PIX_W(PW)) pif ();

  desc_bank_loader #(.PIX_W(PW), .NUM_PIX(NP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pix           (pif.slave),
    .consumer_busy (consumer_busy),
    .load_busy     (load_busy),
    .desc_valid    (desc_valid),
    .desc_update   (desc_update),
    .desc_out      (desc_out),
    .desc_sum      (desc_sum),
    .desc_sumsq    (desc_sumsq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] v);
    pif.pix_in = v;
    pif.pix_valid = 1'b1;
    tick();
    pif.pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    pif.pix_in = '0;
    pif.pix_valid = 1'b0;
    rst_n = 1'b0;
    #12;
    total_cnt++; if ({pif.pix_ready, load_busy, desc_valid, desc_update} !== 4'b0) $display("FAIL reset_ctl got %b want 0000", {pif.pix_ready, load_busy, desc_valid, desc_update}); else pass_cnt++;
    total_cnt++; if ({desc_out, desc_sum, desc_sumsq} !== '0) $display("FAIL reset_data got %h/%0d/%0d want 0", desc_out, desc_sum, desc_sumsq); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_start();
    total_cnt++; if (pif.pix_ready !== 1'b1) $display("FAIL basic_ready got %b want 1", pif.pix_ready); else pass_cnt++;
    beat(8'd10); beat(8'd20); beat(8'd30);
    total_cnt++; if (desc_update !== 1'b0) $display("FAIL basic_early_upd got %b want 0", desc_update); else pass_cnt++;
    beat(8'd40);
    total_cnt++; if (desc_update !== 1'b1) $display("FAIL basic_upd got %b want 1", desc_update); else pass_cnt++;
    total_cnt++; if (desc_out !== 32'h281E140A) $display("FAIL basic_out got %h want 281e140a", desc_out); else pass_cnt++;
    total_cnt++; if (desc_sum !== 11'd100) $display("FAIL basic_sum got %0d want 100", desc_sum); else pass_cnt++;
    total_cnt++; if (desc_sumsq !== 19'd3000) $display("FAIL basic_sumsq got %0d want 3000", desc_sumsq); else pass_cnt++;
    total_cnt++; if ({desc_valid, load_busy} !== 2'b10) $display("FAIL basic_state got %b want 10", {desc_valid, load_busy}); else pass_cnt++;
    tick();
    total_cnt++; if (desc_update !== 1'b0) $display("FAIL basic_pulse_len got %b want 0", desc_update); else pass_cnt++;
  endtask

  task automatic test_toggle();
    logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    int rdy_bad = 0;
    do_start();
    for (int i = 0; i < 7; i++) begin
      if (pif.pix_ready !== 1'b1) rdy_bad++;
      pif.pix_valid = (i % 2 == 0);
      pif.pix_in = (i % 2 == 0) ? vals[i/2] : 8'hEE;
      tick();
    end
    pif.pix_valid = 1'b0;
    total_cnt++; if (rdy_bad != 0) $display("FAIL tog_ready got %0d drops want 0", rdy_bad); else pass_cnt++;
    total_cnt++; if (desc_update !== 1'b1) $display("FAIL tog_upd got %b want 1", desc_update); else pass_cnt++;
    total_cnt++; if (desc_out !== 32'h281E140A) $display("FAIL tog_out got %h want 281e140a", desc_out); else pass_cnt++;
    total_cnt++; if ({desc_sum, desc_sumsq} !== {11'd100, 19'd3000}) $display("FAIL tog_sums got %0d/%0d want 100/3000", desc_sum, desc_sumsq); else pass_cnt++;
    tick();
  endtask

  task automatic test_pending();
    int hold_bad = 0;
    consumer_busy = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) beat(8'd255);
    total_cnt++; if ({load_busy, pif.pix_ready, desc_update} !== 3'b100) $display("FAIL pend_state got %b want 100", {load_busy, pif.pix_ready, desc_update}); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (desc_out !== 32'h281E140A || desc_update !== 1'b0 || load_busy !== 1'b1) hold_bad++;
      tick();
    end
    total_cnt++; if (hold_bad != 0) $display("FAIL pend_hold got %0d bad cycles want 0", hold_bad); else pass_cnt++;
    consumer_busy = 1'b0;
    tick();
    total_cnt++; if ({desc_update, load_busy} !== 2'b10) $display("FAIL pend_promote got %b want 10", {desc_update, load_busy}); else pass_cnt++;
    total_cnt++; if (desc_out !== 32'hFFFFFFFF) $display("FAIL pend_out got %h want ffffffff", desc_out); else pass_cnt++;
    total_cnt++; if (desc_sum !== 11'd1020) $display("FAIL pend_sum got %0d want 1020", desc_sum); else pass_cnt++;
    total_cnt++; if (desc_sumsq !== 19'd260100) $display("FAIL pend_sumsq got %0d want 260100", desc_sumsq); else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    do_start();
    beat(8'd7); beat(8'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if ({load_busy, desc_update} !== 2'b00) $display("FAIL abort_state got %b want 00", {load_busy, desc_update}); else pass_cnt++;
    total_cnt++; if (desc_out !== 32'hFFFFFFFF || desc_sum !== 11'd1020) $display("FAIL abort_keep got %h/%0d want ffffffff/1020", desc_out, desc_sum); else pass_cnt++;
    tick();
    do_start();
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    total_cnt++; if (desc_update !== 1'b1 || desc_out !== 32'h04030201) $display("FAIL abort_reload got %b/%h want 1/04030201", desc_update, desc_out); else pass_cnt++;
    total_cnt++; if ({desc_sum, desc_sumsq} !== {11'd10, 19'd30}) $display("FAIL abort_sums got %0d/%0d want 10/30", desc_sum, desc_sumsq); else pass_cnt++;
    tick();
  endtask

  task automatic test_ignored();
    pif.pix_in = 8'd99;
    pif.pix_valid = 1'b1;
    tick(); tick();
    pif.pix_valid = 1'b0;
    total_cnt++; if ({load_busy, pif.pix_ready, desc_update} !== 3'b000) $display("FAIL idle_pix got %b want 000", {load_busy, pif.pix_ready, desc_update}); else pass_cnt++;
    do_start();
    beat(8'd5);
    start = 1'b1;
    beat(8'd6);
    start = 1'b0;
    beat(8'd7);
    total_cnt++; if (desc_update !== 1'b0 || load_busy !== 1'b1) $display("FAIL mid_start got %b/%b want 0/1", desc_update, load_busy); else pass_cnt++;
    beat(8'd8);
    total_cnt++; if (desc_update !== 1'b1 || desc_out !== 32'h08070605) $display("FAIL ign_out got %b/%h want 1/08070605", desc_update, desc_out); else pass_cnt++;
    total_cnt++; if ({desc_sum, desc_sumsq} !== {11'd26, 19'd174}) $display("FAIL ign_sums got %0d/%0d want 26/174", desc_sum, desc_sumsq); else pass_cnt++;
    tick();
  endtask

  task automatic test_async_reset();
    do_start();
    beat(8'd50); beat(8'd60);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({pif.pix_ready, load_busy, desc_valid, desc_update} !== 4'b0) $display("FAIL arst_ctl got %b want 0000", {pif.pix_ready, load_busy, desc_valid, desc_update}); else pass_cnt++;
    total_cnt++; if ({desc_out, desc_sum, desc_sumsq} !== '0) $display("FAIL arst_data got %h/%0d/%0d want 0", desc_out, desc_sum, desc_sumsq); else pass_cnt++;
    #3;
    rst_n = 1'b1;
    tick();
    do_start();
    beat(8'd10); beat(8'd20); beat(8'd30); beat(8'd40);
    total_cnt++; if (desc_update !== 1'b1 || desc_out !== 32'h281E140A) $display("FAIL arst_reload got %b/%h want 1/281e140a", desc_update, desc_out); else pass_cnt++;
    total_cnt++; if ({desc_sum, desc_sumsq, desc_valid} !== {11'd100, 19'd3000, 1'b1}) $display("FAIL arst_sums got %0d/%0d/%b want 100/3000/1", desc_sum, desc_sumsq, desc_valid); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_pending();
    test_abort();
    test_ignored();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
